// File: rtl/mwc_pkg.sv
// Shared definitions for the microwave-range controller.
//   ST_*        : state encodings
//   mwc_state_e : FSM state type used by microwave_ctrl
package mwc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_DONE  = ST_DONE
  } mwc_state_e;

endpackage

// File: rtl/mwc_duty.sv
// Magnetron duty-cycle generator.
//   clk  : clock
//   rst  : async active-low reset
//   en   : counting enable (controller in RUN)
//   lvl  : latched power level
//   on   : duty output; high for lvl of every 2**LVL_W clocks, always high at max lvl
module mwc_duty #(
  parameter int LVL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LVL_W-1:0] lvl,
  output logic             on
);

  logic [LVL_W-1:0] cnt_q;

  // The count is only observable while en is high, and every entry into RUN
  // restarts the duty period at 0; parking the counter at 0 outside RUN gives
  // exactly that without a separate clear input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
    else         cnt_q <= '0;
  end

  assign on = en & ((&lvl) | (cnt_q < lvl));

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave-range controller: latches cook time and power level, counts the
// cook time down on the tick strobe, duty-cycles the magnetron, and supports
// door interlock, pause/resume, cancel and a timed done indication.
//   clk, rst         : clock, async active-low reset
//   tick             : one-clock time-base strobe
//   start/stop       : start-resume / pause-cancel requests
//   door_open        : interlock, 1 = open (gates p combinationally)
//   tin, plvl        : cook time and power level, sampled on an accepted start
//   p                : magnetron enable
//   busy/done/remain : RUN-or-PAUSE, DONE, remaining ticks
// Build option: define ADD_TIME_EN to let start in RUN add tin to the
// remaining time (saturating); otherwise start in RUN is ignored.
import mwc_pkg::*;

module microwave_ctrl #(
  parameter int TIME_W     = 4,
  parameter int LVL_W      = 2,
  parameter int DONE_TICKS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              door_open,
  input  logic [TIME_W-1:0] tin,
  input  logic [LVL_W-1:0]  plvl,
  output logic              p,
  output logic              busy,
  output logic              done,
  output logic [TIME_W-1:0] remain
);

  localparam int DW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DONE_TICKS - 1);

  mwc_state_e        state_q;
  logic [TIME_W-1:0] remain_q;
  logic [LVL_W-1:0]  plvl_q;
  logic [DW-1:0]     dcnt_q;
  logic              busy_q, done_q;
  logic              start_ok, duty_on;

  // A fresh cook needs a closed door and a non-zero time.
  assign start_ok = start & ~door_open & (tin != '0);

`ifdef ADD_TIME_EN
  logic [TIME_W:0]   sum;
  logic [TIME_W-1:0] remain_sat;
  assign sum        = {1'b0, remain_q} + {1'b0, tin};
  assign remain_sat = sum[TIME_W] ? {TIME_W{1'b1}} : sum[TIME_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      plvl_q   <= '0;
      dcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE && stop) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else if (start_ok) begin
            state_q  <= S_RUN;
            remain_q <= tin;
            plvl_q   <= plvl;
            dcnt_q   <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end else if (state_q == S_DONE && tick) begin
            if (dcnt_q == DLAST) begin
              state_q <= S_IDLE;
              done_q  <= 1'b0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          // Door and stop win over everything; a coincident tick is dropped.
          if (door_open || stop) begin
            state_q <= S_PAUSE;
`ifdef ADD_TIME_EN
          end else if (start && tin != '0) begin
            remain_q <= remain_sat;
`endif
          end else if (tick) begin
            if (remain_q == TIME_W'(1)) begin
              remain_q <= '0;
              state_q  <= S_DONE;
              dcnt_q   <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else if (remain_q != '0) begin
              remain_q <= remain_q - 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            busy_q   <= 1'b0;
          end else if (start && !door_open) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  mwc_duty #(.LVL_W(LVL_W)) u_duty (
    .clk (clk),
    .rst (rst),
    .en  (state_q == S_RUN),
    .lvl (plvl_q),
    .on  (duty_on)
  );

  // Door gating is deliberately combinational so the magnetron drops in the
  // same cycle the door opens.
  assign p      = duty_on & ~door_open;
  assign busy   = busy_q;
  assign done   = done_q;
  assign remain = remain_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
module tb_microwave_ctrl;

  logic       clk, rst, tick, start, stop, door_open;
  logic [3:0] tin;
  logic [1:0] plvl;
  logic       p, busy, done;
  logic [3:0] remain;

  int ntest = 0;
  int nfail = 0;

  microwave_ctrl #(.TIME_W(4), .LVL_W(2), .DONE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .door_open(door_open), .tin(tin), .plvl(plvl),
    .p(p), .busy(busy), .done(done), .remain(remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tk, st, sp, dr;
    logic [3:0] tin;
    logic [1:0] pl;
    logic       ep, eb, ed;
    logic [3:0] er;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic tk, logic st, logic sp, logic dr,
                              logic [3:0] ti, logic [1:0] pl,
                              logic ep, logic eb, logic ed, logic [3:0] er);
    vec_t v;
    v.tk = tk; v.st = st; v.sp = sp; v.dr = dr; v.tin = ti; v.pl = pl;
    v.ep = ep; v.eb = eb; v.ed = ed; v.er = er;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic drive(logic tk, logic st, logic sp, logic dr, logic [3:0] ti, logic [1:0] pl);
    tick = tk; start = st; stop = sp; door_open = dr; tin = ti; plvl = pl;
  endtask

  logic [3:0] add1, add2;

  initial begin
`ifdef ADD_TIME_EN
    add1 = 4'd15; add2 = 4'd15;
`else
    add1 = 4'd12; add2 = 4'd11;
`endif
    //              tk st sp dr tin pl   p  b  d  rem
    vq.push_back(mk(0, 1, 0, 0, 4, 3,   1, 1, 0, 4));  // 0 basic cook start
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 4));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 3));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0));  // 6 -> DONE
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0));  // 10 third tick -> IDLE
    vq.push_back(mk(0, 1, 0, 0, 0, 3,   0, 0, 0, 0));  // tin=0 ignored
    vq.push_back(mk(0, 1, 0, 1, 5, 3,   0, 0, 0, 0));  // door open ignored
    vq.push_back(mk(0, 1, 0, 0, 5, 1,   1, 1, 0, 5));  // 13 duty plvl=1
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 5));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 5));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 1, 0, 4));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 4));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 4));
    vq.push_back(mk(1, 0, 1, 0, 0, 0,   0, 1, 0, 4));  // 19 stop+tick: tick dropped
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 4));
    vq.push_back(mk(0, 1, 0, 0, 9, 0,   1, 1, 0, 4));  // resume, no resample
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 4));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 4));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0));  // 24 cancel
    vq.push_back(mk(0, 1, 0, 0, 2, 0,   0, 1, 0, 2));  // plvl=0
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 3, 3,   1, 1, 0, 3));  // 29 start from DONE
    vq.push_back(mk(1, 0, 0, 1, 0, 0,   0, 1, 0, 3));  // door+tick -> PAUSE
    vq.push_back(mk(0, 1, 0, 1, 7, 0,   0, 1, 0, 3));  // start w/ door open
    vq.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0, 0, 0,   1, 1, 0, 3));  // resume at 3
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 2));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 2));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 12, 3,  1, 1, 0, 12)); // 37
    vq.push_back(mk(0, 1, 0, 0, 6, 3,   1, 1, 0, add1));
    vq.push_back(mk(1, 1, 0, 0, 6, 3,   1, 1, 0, add2));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,   0, 1, 0, add2));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 2,   1, 1, 0, 1));  // 42
    vq.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0));  // stop in DONE

    // Reset with tick pulsing
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    #5;
    chk("rst_p", 0, p, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_remain", 0, remain, 0);
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); rst = 1'b1; tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 0, busy, 0);
    chk("idle_remain", 0, remain, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].tk, vq[i].st, vq[i].sp, vq[i].dr, vq[i].tin, vq[i].pl);
      @(posedge clk); #1;
      chk("vec_p", i, p, vq[i].ep);
      chk("vec_busy", i, busy, vq[i].eb);
      chk("vec_done", i, done, vq[i].ed);
      chk("vec_remain", i, remain, vq[i].er);
    end

    // Door gating of p must be combinational: p drops before the next edge.
    @(negedge clk); drive(0, 1, 0, 0, 5, 3);
    @(posedge clk); #1;
    chk("door_pre_p", 0, p, 1);
    @(negedge clk); drive(0, 0, 0, 1, 0, 0);
    #1;
    chk("door_comb_p", 0, p, 0);
    chk("door_comb_busy", 0, busy, 1);
    @(posedge clk); #1;
    chk("door_pause_remain", 0, remain, 5);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("door_closed_paused_p", 0, p, 0);
    @(negedge clk); drive(0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("final_idle_busy", 0, busy, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
